// File: rtl/mod_counter_pkg.sv
// Shared FSM state encoding and direction/mode constants for the modulo counter.
package mod_counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic DIR_UP       = 1'b1;
   localparam logic DIR_DOWN     = 1'b0;
   localparam logic MODE_WRAP    = 1'b0;
   localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/mod_counter_updown_step.sv
// Combinational +/-1 step generator with terminal detection and wrap value selection.
module updown_step
   import mod_counter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] count,
   input  logic [WIDTH-1:0] limit,
   input  logic             up,
   output logic [WIDTH-1:0] next,
   output logic             terminal
);

   logic [WIDTH-1:0] toggle;
   logic [WIDTH-1:0] inc_dec;

   // Bit i flips when every lower bit is 1 (counting up) or 0 (counting down).
   assign toggle[0] = 1'b1;
   for (genvar i = 1; i < WIDTH; i++) begin : g_tog
      assign toggle[i] = toggle[i-1] & (count[i-1] ~^ up);
   end

   assign inc_dec  = count ^ toggle;
   assign terminal = (up == DIR_UP) ? (count >= limit) : (count == '0);
   assign next     = terminal ? ((up == DIR_UP) ? '0 : limit) : inc_dec;

endmodule

// File: rtl/mod_counter.sv
// Programmable up/down modulo counter with wrap or one-shot mode, load and limit write.
module mod_counter
   import mod_counter_pkg::*;
#(
   parameter int          WIDTH       = 32,
   parameter logic [63:0] RESET_LIMIT = 64'd4999999,
   parameter int          AUTO_START  = 1
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_hold,
   input  logic             i_up,
   input  logic             i_mode,
   input  logic             i_start,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_limit_wr,
   input  logic [WIDTH-1:0] i_limit,
   output logic [WIDTH-1:0] o_count,
   output logic             o_tick,
   output logic             o_busy,
   output logic             o_done
);

   localparam logic [WIDTH-1:0] LIMIT_INIT = RESET_LIMIT[WIDTH-1:0];
   localparam state_t           STATE_INIT = (AUTO_START != 0) ? ST_RUN : ST_IDLE;

   state_t           state, state_nx;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] limit;
   logic             tick;
   logic [WIDTH-1:0] step_next;
   logic             terminal;
   logic             counting;

   updown_step #(.WIDTH(WIDTH)) u_step (
      .count    (count),
      .limit    (limit),
      .up       (i_up),
      .next     (step_next),
      .terminal (terminal)
   );

   // Load wins over counting; hold only matters while running.
   assign counting = (state == ST_RUN) && !i_hold && !i_load;

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE, ST_DONE: if (i_start) state_nx = ST_RUN;
         ST_RUN:           if (counting && terminal && (i_mode == MODE_ONESHOT)) state_nx = ST_DONE;
         default:          state_nx = STATE_INIT;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state <= STATE_INIT;
         count <= '0;
         limit <= LIMIT_INIT;
         tick  <= 1'b0;
      end else begin
         state <= state_nx;
         tick  <= counting && terminal;
         if (i_limit_wr) limit <= i_limit;
         if (i_load)
            count <= i_load_val;
         else if (counting)
            count <= step_next;
      end
   end

   assign o_count = count;
   assign o_tick  = tick;
   assign o_busy  = (state == ST_RUN);
   assign o_done  = (state == ST_DONE);

endmodule

// File: tb/tb_mod_counter.sv
// Directed and randomized checks of mod_counter (8-bit auto-start and 32-bit idle-start instances).
module tb_mod_counter;

   logic        i_clk, i_rstn;
   logic        hold, up, mode, start, load, limit_wr;
   logic [7:0]  load_val, limit;
   logic [7:0]  count;
   logic        tick, busy, done;
   logic        w_hold, w_up, w_mode, w_start, w_load, w_limit_wr;
   logic [31:0] w_load_val, w_limit, w_count;
   logic        w_tick, w_busy, w_done;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference state: index 0 = 8-bit instance, 1 = 32-bit instance; st 0 idle, 1 run, 2 done.
   longint unsigned m_cnt[2], m_lim[2];
   logic            m_tick[2];
   int              m_st[2];

   mod_counter #(.WIDTH(8), .RESET_LIMIT(64'd9), .AUTO_START(1)) u_dut (
      .i_clk(i_clk), .i_rstn(i_rstn), .i_hold(hold), .i_up(up), .i_mode(mode),
      .i_start(start), .i_load(load), .i_load_val(load_val), .i_limit_wr(limit_wr),
      .i_limit(limit), .o_count(count), .o_tick(tick), .o_busy(busy), .o_done(done));

   mod_counter #(.WIDTH(32), .RESET_LIMIT(64'hFFFFFFFF), .AUTO_START(0)) u_wide (
      .i_clk(i_clk), .i_rstn(i_rstn), .i_hold(w_hold), .i_up(w_up), .i_mode(w_mode),
      .i_start(w_start), .i_load(w_load), .i_load_val(w_load_val), .i_limit_wr(w_limit_wr),
      .i_limit(w_limit), .o_count(w_count), .o_tick(w_tick), .o_busy(w_busy), .o_done(w_done));

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input int k, input longint unsigned mask, input longint unsigned rl,
                             input int auto_st, input logic h, input logic u, input logic md,
                             input logic st, input logic ld, input longint unsigned lv,
                             input logic wr, input longint unsigned lin);
      longint unsigned nlim;
      nlim = wr ? (lin & mask) : m_lim[k];
      if (!i_rstn) begin
         m_cnt[k]  = 0;
         m_tick[k] = 1'b0;
         m_lim[k]  = rl;
         m_st[k]   = auto_st ? 1 : 0;
      end else begin
         m_tick[k] = 1'b0;
         if (ld) begin
            m_cnt[k] = lv & mask;
            if (st && m_st[k] != 1) m_st[k] = 1;
         end else if (m_st[k] == 1 && !h) begin
            if (u) begin
               if (m_cnt[k] >= m_lim[k]) begin m_cnt[k] = 0; m_tick[k] = 1'b1; end
               else m_cnt[k] = m_cnt[k] + 1;
            end else begin
               if (m_cnt[k] == 0) begin m_cnt[k] = m_lim[k]; m_tick[k] = 1'b1; end
               else m_cnt[k] = m_cnt[k] - 1;
            end
            if (m_tick[k] && md) m_st[k] = 2;
         end else if (m_st[k] != 1 && st) begin
            m_st[k] = 1;
         end
         m_lim[k] = nlim;
      end
   endtask

   // One clock: advance both models on the edge, then compare all outputs just after it.
   task automatic cycle();
      @(posedge i_clk);
      model_step(0, 64'hFF, 64'd9, 1, hold, up, mode, start, load, load_val, limit_wr, limit);
      model_step(1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0, w_hold, w_up, w_mode, w_start, w_load,
                 w_load_val, w_limit_wr, w_limit);
      #1;
      chk("cnt8",  count, m_cnt[0]);
      chk("tick8", tick,  m_tick[0]);
      chk("busy8", busy,  (m_st[0] == 1));
      chk("done8", done,  (m_st[0] == 2));
      chk("cnt32",  w_count, m_cnt[1]);
      chk("tick32", w_tick,  m_tick[1]);
      chk("busy32", w_busy,  (m_st[1] == 1));
      chk("done32", w_done,  (m_st[1] == 2));
   endtask

   initial begin
      i_rstn = 1'b0;
      hold = 0; up = 1; mode = 0; start = 0; load = 0; load_val = 0; limit_wr = 0; limit = 0;
      w_hold = 0; w_up = 1; w_mode = 0; w_start = 0; w_load = 0; w_load_val = 0;
      w_limit_wr = 0; w_limit = 0;
      m_cnt = '{0, 0}; m_lim = '{0, 0}; m_tick = '{0, 0}; m_st = '{0, 0};

      cycle(); cycle();
      chk("rst_cnt",    count, 0);
      chk("rst_tick",   tick, 0);
      chk("rst_busy",   busy, 1);
      chk("rst_w_busy", w_busy, 0);
      chk("rst_w_done", w_done, 0);

      // Wrap up-count on the 8-bit unit; load+start from idle on the 32-bit unit
      i_rstn = 1'b1;
      w_load = 1; w_start = 1; w_load_val = 32'hFFFF_FFFE;
      cycle();
      w_load = 0; w_start = 0;
      chk("w_ld_cnt",  w_count, 64'hFFFF_FFFE);
      chk("w_ld_busy", w_busy, 1);
      cycle();
      chk("w_max_cnt",  w_count, 64'hFFFF_FFFF);
      chk("w_max_tick", w_tick, 0);
      cycle();
      chk("w_wrap_cnt",  w_count, 0);
      chk("w_wrap_tick", w_tick, 1);
      repeat (17) cycle();
      chk("wrap20_cnt",  count, 0);
      chk("wrap20_tick", tick, 1);

      // One-shot down-count from 5
      load = 1; load_val = 8'd5; up = 0; mode = 1;
      cycle();
      load = 0;
      chk("os_load", count, 5);
      repeat (5) cycle();
      chk("os_zero", count, 0);
      cycle();
      chk("os_term_cnt",  count, 9);
      chk("os_term_tick", tick, 1);
      chk("os_term_done", done, 1);
      repeat (2) cycle();
      chk("os_hold_cnt",  count, 9);
      chk("os_hold_tick", tick, 0);
      start = 1;
      cycle();
      start = 0;
      chk("os_restart_busy", busy, 1);
      chk("os_restart_cnt",  count, 9);
      cycle();
      chk("os_run_cnt", count, 8);

      // Hold freezes, load overrides hold
      up = 1; mode = 0; hold = 1; load = 1; load_val = 8'd4;
      cycle();
      load = 0;
      repeat (5) cycle();
      chk("hold_cnt",  count, 4);
      chk("hold_tick", tick, 0);
      hold = 0;
      cycle();
      chk("release_cnt", count, 5);
      hold = 1; load = 1; load_val = 8'd2;
      cycle();
      load = 0;
      chk("load_in_hold", count, 2);

      // Limit reduced below current count
      load = 1; load_val = 8'd7;
      cycle();
      load = 0; limit_wr = 1; limit = 8'd3;
      cycle();
      limit_wr = 0; hold = 0;
      cycle();
      chk("lim_cut_cnt",  count, 0);
      chk("lim_cut_tick", tick, 1);
      repeat (3) cycle();
      chk("lim4_cnt", count, 3);
      cycle();
      chk("lim4_wrap_cnt",  count, 0);
      chk("lim4_wrap_tick", tick, 1);

      // Reset glitch between edges, then a real reset restoring the limit
      hold = 1; load = 1; load_val = 8'd6;
      cycle();
      load = 0;
      i_rstn = 1'b0; #2; i_rstn = 1'b1;
      cycle();
      chk("glitch_cnt", count, 6);
      i_rstn = 1'b0;
      cycle();
      i_rstn = 1'b1;
      chk("sync_rst_cnt",  count, 0);
      chk("sync_rst_tick", tick, 0);
      hold = 0;
      repeat (9) cycle();
      chk("lim_restore_cnt", count, 9);
      cycle();
      chk("lim_restore_wrap", tick, 1);

      // Randomized traffic on both instances
      repeat (400) begin
         i_rstn   = ($urandom_range(0, 99) != 0);
         hold     = ($urandom_range(0, 7) == 0);
         up       = $urandom_range(0, 1);
         mode     = ($urandom_range(0, 3) == 0);
         start    = ($urandom_range(0, 5) == 0);
         load     = ($urandom_range(0, 9) == 0);
         load_val = 8'($urandom_range(0, 255));
         limit_wr = ($urandom_range(0, 11) == 0);
         limit    = 8'($urandom_range(0, 20));
         w_hold     = ($urandom_range(0, 7) == 0);
         w_up       = $urandom_range(0, 1);
         w_mode     = ($urandom_range(0, 3) == 0);
         w_start    = ($urandom_range(0, 5) == 0);
         w_load     = ($urandom_range(0, 9) == 0);
         w_load_val = ($urandom_range(0, 1) != 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : 32'($urandom_range(0, 15));
         w_limit_wr = ($urandom_range(0, 11) == 0);
         w_limit    = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 12));
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, counter/limit width, legal range 2..64.
REQ-002 SHALL have parameter RESET_LIMIT, default 4999999, limit register reset value, SHALL be < 2^WIDTH.
REQ-003 SHALL have parameter AUTO_START, default 1, 1 = FSM leaves reset in RUN, 0 = in IDLE.
REQ-004 SHALL have ports (one clock; reset is synchronous and active-low):
  i_clk  in  1  sole clock, all state on rising edge
  i_rstn  in  1  synchronous active-low reset
  i_hold  in  1  1 = freeze count in RUN
  i_up  in  1  1 = count up, 0 = count down
  i_mode  in  1  0 = wrap (free-run), 1 = one-shot
  i_start  in  1  pulse, IDLE/DONE -> RUN
  i_load  in  1  pulse, count <= i_load_val
  i_load_val  in  WIDTH  load value
  i_limit_wr  in  1  pulse, limit register <= i_limit
  i_limit  in  WIDTH  new limit
  o_count  out  WIDTH  current count (register)
  o_tick  out  1  terminal-count pulse (register)
  o_busy  out  1  state == RUN
  o_done  out  1  state == DONE

Function
REQ-005 SHALL implement FSM states IDLE, RUN, DONE; o_busy/o_done decoded from state only.
REQ-006 SHALL count only in RUN with i_hold=0 and i_load=0; count holds in IDLE, DONE, or when i_hold=1.
REQ-007 SHALL define terminal: up: count >= limit register; down: count == 0.
REQ-008 SHALL step count each counting cycle: up non-terminal +1, up terminal -> 0; down non-terminal -1, down terminal -> limit register.
REQ-009 SHALL assert o_tick for exactly one cycle, in the cycle o_count shows the post-terminal value; o_tick low in every other cycle.
REQ-010 SHALL, on terminal with i_mode=1, move RUN -> DONE (count holds post-terminal value); with i_mode=0 stay RUN; i_mode sampled at the terminal cycle.
REQ-011 SHALL accept i_start only in IDLE or DONE (-> RUN next cycle, count unchanged); ignore it in RUN.
REQ-012 SHALL apply i_load in any state, highest priority over hold and counting; no tick generated; state unchanged; value not range-checked.
REQ-013 SHALL latch i_limit on i_limit_wr with one-cycle latency; terminal evaluation in the same cycle uses the old limit.
REQ-014 SHALL never overflow: up-count bounded by limit; count above a reduced limit terminates on the next counting cycle.
REQ-015 SHALL treat i_load and i_start together in IDLE as both taking effect (loaded value, state RUN).

Reset
REQ-016 SHALL, on rising i_clk with i_rstn=0, set o_count=0, o_tick=0, limit register=RESET_LIMIT, state=RUN if AUTO_START else IDLE; overrides all other inputs.
REQ-017 SHALL ignore i_rstn between clock edges (no asynchronous path).

Structure
REQ-018 SHALL place state enum and terminal/step encoding constants in shared package mod_counter_pkg.
REQ-019 SHALL use one combinational sub-module updown_step (WIDTH-parametrised toggle/carry-lookahead +/-1 generator with terminal flag).

Verification (WIDTH=8, RESET_LIMIT=9 unless stated)
REQ-020 Reset, AUTO_START=1, up, wrap, 20 cycles -> counts 0..9,0..9; o_tick high only with each return to 0 (period 10).
REQ-021 Load 5, down, one-shot, start from IDLE -> 5,4,3,2,1,0,9; o_tick with 9; o_done=1, count stays 9; i_start -> RUN again.
REQ-022 Up at count 7, write limit 3 -> next counting cycle count 0 with o_tick; subsequent period 4.
REQ-023 i_hold=1 at count 4 for 5 cycles -> count 4, no tick; release -> 5; i_load 2 during hold -> count 2.
REQ-024 i_rstn=0 for one edge at count 6 after limit write 3 -> count 0, limit 9, o_tick 0; i_rstn pulse between edges -> no effect.
REQ-025 WIDTH=32, RESET_LIMIT=32'hFFFFFFFF, load 32'hFFFFFFFE, up -> FFFFFFFF then 0 with o_tick.
